seq_stream_tx_100_010: RTL and testbench

//   Serial stimulus transmitter for the 100/010 sequence-detector path.
//   - Accepts one frame command per valid/ready handshake.
//   - Serialises raw data or repeated 100/010 patterns onto a 1-bit stream, one bit per clock.
//   - Keeps golden overlapping counts of the 100 and 010 triples it actually emitted,
//     so a detector downstream can be scored against them.

---
 rtl/seq_tx_pkg.sv | 26 ++
 rtl/seq_track_100_010.sv | 51 +++++
 rtl/seq_stream_tx_100_010.sv | 162 ++++++++++++++++
 tb/tb_seq_stream_tx_100_010.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - shared mode codes, FSM states and pattern constants for the 100/010 stream transmitter
package seq_tx_pkg;

   typedef enum logic [1:0] {
      MODE_RAW    = 2'b00,
      MODE_REP100 = 2'b01,
      MODE_REP010 = 2'b10,
      MODE_PRBS   = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam logic [2:0] PAT_100   = 3'b100;
   localparam logic [2:0] PAT_010   = 3'b010;
   localparam logic [6:0] PRBS_SEED = 7'h7F;

   // One step of the x^7+x^6+1 Fibonacci LFSR; the output bit is taken from [6].
   function automatic logic [6:0] prbs7_step(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

endpackage

// File: rtl/seq_track_100_010.sv
// rtl/seq_track_100_010.sv - golden overlapping counter of 100 and 010 triples on a valid-qualified bit stream
module seq_track_100_010
   import seq_tx_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stream_bit,
   input  logic          bit_valid,
   input  logic          clr,
   output logic [CW-1:0] cnt_100,
   output logic [CW-1:0] cnt_010
);

   logic       h1;
   logic       h0;
   logic [1:0] fill;
   logic [2:0] trip;
   logic       hit_100;
   logic       hit_010;

   assign trip    = {h1, h0, stream_bit};
   assign hit_100 = bit_valid && (fill == 2'd2) && (trip == PAT_100);
   assign hit_010 = bit_valid && (fill == 2'd2) && (trip == PAT_010);

   // History spans frames and idle gaps; only rst forgets it.
   always_ff @(posedge clk) begin
      if (rst) begin
         h1   <= 1'b0;
         h0   <= 1'b0;
         fill <= 2'd0;
      end else if (bit_valid) begin
         h1 <= h0;
         h0 <= stream_bit;
         if (fill != 2'd2) fill <= fill + 2'd1;
      end
   end

   // Saturating counters; a clear overrides a coincident increment.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_100 <= '0;
         cnt_010 <= '0;
      end else begin
         if (hit_100 && (cnt_100 != {CW{1'b1}})) cnt_100 <= cnt_100 + 1'b1;
         if (hit_010 && (cnt_010 != {CW{1'b1}})) cnt_010 <= cnt_010 + 1'b1;
      end
   end

endmodule

// File: rtl/seq_stream_tx_100_010.sv
// rtl/seq_stream_tx_100_010.sv - serial RAW/REP100/REP010 frame transmitter with golden triple counts; SEQ_TX_PRBS_EN adds PRBS7 mode
module seq_stream_tx_100_010
   import seq_tx_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LENW  = 5,
   parameter int CW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [LENW-1:0]  in_len,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clr_cnt,
   output logic             o,
   output logic             o_valid,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    cnt_100,
   output logic [CW-1:0]    cnt_010
);

   localparam int NW = LENW + 2;

   state_t           state_q, state_d;
   mode_t            mode_q, acc_mode, src_mode;
   logic [WIDTH-1:0] data_q, src_data;
   logic [1:0]       phase_q, src_phase, phase_nxt;
   logic [NW-1:0]    rem_q, acc_len, raw_n, rep_n;
   logic             accept, bit_sel, load, advance;
   logic             o_d, o_valid_d, done_d;
`ifdef SEQ_TX_PRBS_EN
   logic [6:0]       lfsr_q, src_lfsr;
`endif

   assign in_ready = (state_q == IDLE) && !rst;
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != IDLE);

   assign raw_n = ({2'b00, in_len} > NW'(WIDTH)) ? NW'(WIDTH) : {2'b00, in_len};
   assign rep_n = {1'b0, in_len, 1'b0} + {2'b00, in_len};

   // Decode the command; without PRBS support mode 11 is an alias of RAW.
   always_comb begin
      acc_mode = mode_t'(in_mode);
`ifndef SEQ_TX_PRBS_EN
      if (acc_mode == MODE_PRBS) acc_mode = MODE_RAW;
`endif
      acc_len = ((acc_mode == MODE_REP100) || (acc_mode == MODE_REP010)) ? rep_n : raw_n;
   end

   // Bit source: the incoming command while idle, the latched frame while shifting.
   always_comb begin
      if (state_q == IDLE) begin
         src_mode  = acc_mode;
         src_data  = in_data;
         src_phase = 2'd0;
      end else begin
         src_mode  = mode_q;
         src_data  = data_q;
         src_phase = phase_q;
      end
`ifdef SEQ_TX_PRBS_EN
      src_lfsr = (state_q == IDLE) ? PRBS_SEED : lfsr_q;
`endif
      phase_nxt = (src_phase == 2'd2) ? 2'd0 : src_phase + 2'd1;
      case (src_mode)
         MODE_REP100: bit_sel = PAT_100[2'd2 - src_phase];
         MODE_REP010: bit_sel = PAT_010[2'd2 - src_phase];
`ifdef SEQ_TX_PRBS_EN
         MODE_PRBS:   bit_sel = src_lfsr[6];
`endif
         default:     bit_sel = src_data[WIDTH-1];
      endcase
   end

   // Next state and next registered outputs.
   always_comb begin
      state_d   = state_q;
      o_d       = 1'b0;
      o_valid_d = 1'b0;
      done_d    = 1'b0;
      load      = 1'b0;
      advance   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               load = 1'b1;
               if (acc_len == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = SHIFT;
                  o_valid_d = 1'b1;
                  o_d       = bit_sel;
               end
            end
         end
         SHIFT: begin
            if (rem_q == NW'(1)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               o_valid_d = 1'b1;
               o_d       = bit_sel;
               advance   = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         o       <= 1'b0;
         o_valid <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         o       <= o_d;
         o_valid <= o_valid_d;
         done    <= done_d;
      end
   end

   // Frame datapath: latch on accept, step once per emitted bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= MODE_RAW;
         data_q  <= '0;
         phase_q <= 2'd0;
         rem_q   <= '0;
`ifdef SEQ_TX_PRBS_EN
         lfsr_q  <= PRBS_SEED;
`endif
      end else if (load || advance) begin
         mode_q  <= src_mode;
         data_q  <= src_data << 1;
         phase_q <= phase_nxt;
         rem_q   <= load ? acc_len : rem_q - NW'(1);
`ifdef SEQ_TX_PRBS_EN
         lfsr_q  <= prbs7_step(src_lfsr);
`endif
      end
   end

   seq_track_100_010 #(.CW(CW)) u_track (
      .clk        (clk),
      .rst        (rst),
      .stream_bit (o),
      .bit_valid  (o_valid),
      .clr        (clr_cnt),
      .cnt_100    (cnt_100),
      .cnt_010    (cnt_010)
   );

endmodule

// File: tb/tb_seq_stream_tx_100_010.sv
// tb/tb_seq_stream_tx_100_010.sv - directed self-checking bench for seq_stream_tx_100_010
module tb_seq_stream_tx_100_010;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_mode = 2'b00;
   logic [4:0]  in_len = 5'd0;
   logic [15:0] in_data = 16'h0000;
   logic        clr_cnt = 1'b0;
   logic        o, o_valid, busy, done;
   logic [7:0]  cnt_100, cnt_010;

   int total = 0;
   int bad   = 0;

   seq_stream_tx_100_010 dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_mode  (in_mode),
      .in_len   (in_len),
      .in_data  (in_data),
      .clr_cnt  (clr_cnt),
      .o        (o),
      .o_valid  (o_valid),
      .busy     (busy),
      .done     (done),
      .cnt_100  (cnt_100),
      .cnt_010  (cnt_010)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rdy_in_rst", 32'(in_ready), 32'd0);
      rst = 1'b0;
   endtask

   task automatic chk_cnt(input string tag, input logic [7:0] e100, input logic [7:0] e010);
      chk({tag, "_c100"}, 32'(cnt_100), 32'(e100));
      chk({tag, "_c010"}, 32'(cnt_010), 32'(e010));
   endtask

   // bits holds the expected stream, first bit at index n-1.
   task automatic run_frame(input string tag, input logic [1:0] m, input logic [4:0] len,
                            input logic [15:0] d, input int n, input logic [31:0] bits);
      @(negedge clk);
      in_mode = m; in_len = len; in_data = d; in_valid = 1'b1;
      chk({tag, "_rdy0"}, 32'(in_ready), 32'd1);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         chk({tag, "_ov"}, 32'(o_valid), 32'd1);
         chk({tag, "_bit"}, 32'(o), 32'(bits[n-1-i]));
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_ov_done"}, 32'(o_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_done_off"}, 32'(done), 32'd0);
      chk({tag, "_rdy1"}, 32'(in_ready), 32'd1);
   endtask

   task automatic send_wait(input logic [1:0] m, input logic [4:0] len);
      int k;
      @(negedge clk);
      in_mode = m; in_len = len; in_data = 16'h0000; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!done && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      // reset state
      do_reset();
      #1;
      chk("rst_o", 32'(o), 32'd0);
      chk("rst_ov", 32'(o_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'd1);
      chk_cnt("rst", 8'd0, 8'd0);

      // 1: RAW 9000 len 4 -> 1001
      run_frame("raw4", 2'b00, 5'd4, 16'h9000, 4, 32'b1001);
      chk_cnt("raw4", 8'd1, 8'd0);

      // 2: REP010 x3 -> 010010010
      do_reset();
      run_frame("rep010", 2'b10, 5'd3, 16'h0000, 9, 32'b010010010);
      chk_cnt("rep010", 8'd2, 8'd3);

      // 3: REP100 x2 -> 100100
      do_reset();
      run_frame("rep100", 2'b01, 5'd2, 16'h0000, 6, 32'b100100);
      chk_cnt("rep100", 8'd2, 8'd1);

      // 4: zero-length RAW
      run_frame("len0", 2'b00, 5'd0, 16'hFFFF, 0, 32'd0);
      chk_cnt("len0", 8'd2, 8'd1);

      // mode 11: PRBS7 from seed 7F, else RAW alias
`ifdef SEQ_TX_PRBS_EN
      run_frame("mode3", 2'b11, 5'd3, 16'hA000, 3, 32'b111);
`else
      run_frame("mode3", 2'b11, 5'd3, 16'hA000, 3, 32'b101);
`endif

      // RAW length clamps at WIDTH
      do_reset();
      run_frame("raw_clamp", 2'b00, 5'd20, 16'hC003, 16, 32'hC003);

      // 5: REP100 x10 aborted by rst after 5 bits
      do_reset();
      @(negedge clk);
      in_mode = 2'b01; in_len = 5'd10; in_data = 16'h0000; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         chk("abort_bit", 32'(o), 32'(i == 0 || i == 3));
      end
      chk("abort_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ov", 32'(o_valid), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk_cnt("abort", 8'd0, 8'd0);
      rst = 1'b0;
      #1;
      chk("abort_rdy", 32'(in_ready), 32'd1);
      chk("abort_busy0", 32'(busy), 32'd0);
      @(negedge clk);
      chk("abort_nodone", 32'(done), 32'd0);

      // 6: back-to-back RAW '0' then '10' with in_valid held
      do_reset();
      @(negedge clk);
      in_mode = 2'b00; in_len = 5'd1; in_data = 16'h0000; in_valid = 1'b1;
      chk("b2b_rdy_a", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("b2b_rdy_busy", 32'(in_ready), 32'd0);
      chk("b2b_a_bit", 32'(o), 32'd0);
      in_len = 5'd2; in_data = 16'h8000;
      @(negedge clk);
      chk("b2b_a_done", 32'(done), 32'd1);
      chk("b2b_rdy_done", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("b2b_rdy_b", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_b_bit0", 32'(o), 32'd1);
      @(negedge clk);
      chk("b2b_b_bit1", 32'(o), 32'd0);
      @(negedge clk);
      chk("b2b_b_done", 32'(done), 32'd1);
      @(negedge clk);
      chk_cnt("b2b", 8'd0, 8'd1);

      // clear coinciding with an increment
      in_mode = 2'b00; in_len = 5'd2; in_data = 16'h8000; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("clr_pre", 32'(cnt_010), 32'd1);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      chk_cnt("clr", 8'd0, 8'd0);
      @(negedge clk);

      // saturation: 9 x REP100 len 31 = 837 continuous bits
      do_reset();
      for (int f = 0; f < 9; f++) send_wait(2'b01, 5'd31);
      chk_cnt("sat", 8'd255, 8'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
